booth2_iter_mul: RTL

Iterative radix-4 (2-bit Booth) multiplier that consumes Booth partial products one per cycle and accumulates them into a full 128-bit product. It is the accumulation side of the Booth2 partial-product encoding used by the execute stage. It serves all four RV64 multiply flavours (MUL/MULH/MULHSU/MULHU) through per-operand signedness flags. Valid/ready handshakes on input and output let it sit behind the issue logic and in front of writeback.

---
 rtl/booth2_iter_mul.sv | 103 ++++++++++
 1 files changed

// File: rtl/booth2_iter_mul.sv
// booth2_iter_mul
//   Iterative radix-4 Booth multiplier. It retires one Booth partial product
//   per cycle into a 130-bit accumulator and returns the low 128 bits of the
//   full 64x64 product. Per-operand signedness flags cover
//   MUL/MULH/MULHSU/MULHU.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   flush               synchronous abort; returns to IDLE and drops any result
//   in_valid/in_ready   operand handshake (in_ready = IDLE)
//   op_a, op_b          multiplicand / multiplier (64 b)
//   a_signed, b_signed  two's-complement interpretation per operand
//   out_valid/out_ready result handshake (out_valid = DONE)
//   result              128-bit product, held until overwritten by the next op
module booth2_iter_mul (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  op_a,
  input  logic [63:0]  op_b,
  input  logic         a_signed,
  input  logic         b_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [129:0]   a_sh;     // multiplicand, pre-shifted by 2i for step i
  logic [65:0]    b_sh;     // multiplier, shifted right by 2i for step i
  logic           b_m1;     // B66[2i-1], zero on step 0
  logic [129:0]   acc, pp, a_x2, acc_nxt;
  logic [5:0]     cnt;
  logic [2:0]     slice;
  logic           ext_a, ext_b, accept, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    ext_a   = a_signed & op_a[63];
    ext_b   = b_signed & op_b[63];
    accept  = in_ready & in_valid & ~flush;
    last    = (state == BUSY) && (cnt == 6'd32);
    slice   = {b_sh[1:0], b_m1};
    a_x2    = {a_sh[128:0], 1'b0};
    case (slice)
      3'b001, 3'b010: pp = a_sh;
      3'b011:         pp = a_x2;
      3'b100:         pp = -a_x2;
      3'b101, 3'b110: pp = -a_sh;
      default:        pp = '0;   // 000 / 111
    endcase
    acc_nxt = acc + pp;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      b_m1   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      // Sign-extend each operand to 66 b, then A on out to the full 130 b.
      a_sh <= {{64{ext_a}}, ext_a, ext_a, op_a};
      b_sh <= {ext_b, ext_b, op_b};
      b_m1 <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 2;
      b_sh <= b_sh >> 2;
      b_m1 <= b_sh[1];
      cnt  <= cnt + 6'd1;
      // A flush on the final step must not leak a partial result.
      if (last && !flush) result <= acc_nxt[127:0];
    end
  end

endmodule
